// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry decoupling queue.
// Holds the fetch PC, runs the ibus valid/data_ok handshake and buffers
// {pc, instr} pairs so decode can stall without stalling the bus.

package fetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_data_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output fetch_data_t dataF,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

    state_e            state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    // Address of the outstanding request; pc may move on a redirect while
    // the bus still needs the original address held stable.
    logic [63:0]       req_addr_q, req_addr_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [63:0]       pc_mem_q [DEPTH];
    logic [63:0]       pc_mem_d [DEPTH];
    logic [31:0]       instr_mem_q [DEPTH];
    logic [31:0]       instr_mem_d [DEPTH];

    logic full;
    logic req_valid;
    logic push;
    logic pop;

    // Bus request, FSM next state and PC update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        full       = (count_q == CntW'(DEPTH));
        req_valid  = 1'b0;
        push       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Space is reserved up front, so a push can never overflow.
                req_valid = !full && !redirect;
                push      = req_valid && iresp.data_ok;
                if (req_valid && !iresp.data_ok) begin
                    state_d    = StBusy;
                    req_addr_d = pc_q;
                end
            end
            StBusy: begin
                req_valid = 1'b1;
                push      = iresp.data_ok && !redirect;
                if (iresp.data_ok) begin
                    state_d = StIdle;
                end else if (redirect) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Wrong-path response still owed by the bus; drop it.
                req_valid = 1'b1;
                if (iresp.data_ok) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + 64'd4;
        end

        ireq.valid = req_valid && !reset;
        ireq.addr  = (state_q == StIdle) ? pc_q : req_addr_q;
    end

    // Queue pointers, occupancy and storage writes.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        pop         = (count_q != '0) && out_ready && !redirect;

        if (push) begin
            pc_mem_d[tail_q]    = pc_q;
            instr_mem_d[tail_q] = iresp.data;
            tail_d              = tail_q + PtrW'(1);
        end
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        dataF.valid     = (count_q != '0) && !reset;
        dataF.pc        = pc_mem_q[head_q];
        dataF.raw_instr = instr_mem_q[head_q];
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule
